// File: rtl/d_cache.sv
// Direct-mapped write-through, no-write-allocate data cache. Load hits return in the same cycle; a miss refills in 1+WORDS cycles and a store takes 2.
// miss is the pipeline stall; memory-side stalls are absorbed by waiting on mem_ack.
module d_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [2:0]            load_store,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  miss,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t                  state, state_nx;
  logic [OFFSET_BITS-1:0]  cnt;
  logic [DATA_WIDTH-1:0]   data_arr [LINES*WORDS];
  logic [TAG_BITS-1:0]     tag_arr  [LINES];
  logic [LINES-1:0]        valid;

  logic [OFFSET_BITS-1:0]  offset;
  logic [INDEX_BITS-1:0]   index;
  logic [TAG_BITS-1:0]     tag;
  logic                    hit, last;
  logic [DATA_WIDTH-1:0]   cur_word, load_val, st_wdata, merged;
  logic [3:0]              st_wstrb;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;

  assign offset   = addr[OFFSET_BITS+1:2];
  assign index    = addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign tag      = addr[31 -: TAG_BITS];
  assign hit      = valid[index] && (tag_arr[index] == tag);
  assign last     = (cnt == {OFFSET_BITS{1'b1}});
  assign cur_word = data_arr[{index, offset}];
  assign byte_sel = cur_word[{addr[1:0], 3'b000} +: 8];
  assign half_sel = addr[1] ? cur_word[31:16] : cur_word[15:0];

  // State register plus refill word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE)
        cnt <= '0;
      else if (state == REFILL && mem_ack)
        cnt <= cnt + 1'b1;
    end
  end

  // A line being refilled is invalid until its last word lands, so an abandoned refill never hits
  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (state == IDLE && memread && !memwrite && !hit)
      valid[index] <= 1'b0;
    else if (state == REFILL && mem_ack && last)
      valid[index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == REFILL && mem_ack) begin
      data_arr[{index, cnt}] <= mem_rdata;
      if (last)
        tag_arr[index] <= tag;
    end else if (!rst && state == WRITE && mem_ack && hit) begin
      data_arr[{index, offset}] <= merged;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (memwrite)
          state_nx = WRITE;
        else if (memread && !hit)
          state_nx = REFILL;
      end
      REFILL: if (mem_ack && last) state_nx = IDLE;
      WRITE:  if (mem_ack) state_nx = WDONE;
      WDONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    st_wdata = wdata;
    st_wstrb = 4'b1111;
    case (load_store)
      3'b101: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      3'b110: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      merged[i*8 +: 8] = st_wstrb[i] ? st_wdata[i*8 +: 8] : cur_word[i*8 +: 8];
  end

  always_comb begin
    case (load_store)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = cur_word;
      3'b011:  load_val = {24'b0, byte_sel};
      3'b100:  load_val = {16'b0, half_sel};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    miss      = 1'b0;
    readdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (memwrite)
            miss = 1'b1;
          else if (memread) begin
            if (hit) readdata = load_val;
            else     miss     = 1'b1;
          end
        end
      end
      REFILL: begin
        miss     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, index, cnt, 2'b00};
      end
      WRITE: begin
        miss      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = st_wdata;
        mem_wstrb = st_wstrb;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: vector table of CPU accesses, memory transactions checked against an expected-transaction queue.
module tb_d_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [2:0]  load_store;
  logic [31:0] addr, wdata, readdata;
  logic        miss, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks   = 0;
  int failures = 0;

  d_cache dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .load_store(load_store), .addr(addr), .wdata(wdata), .readdata(readdata),
    .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  ls;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic [31:0] rdata;
    logic [31:0] wdat;
    logic [3:0]  strb;
  } vec_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Backing memory: acks every requested cycle, compares each transaction with the next expected one
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !rst) begin
      txn_t   e;
      logic [31:0] w;
      mem_ack = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_mem_txn", mem_addr, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        check("mem_addr", mem_addr, e.a);
        if (e.we) begin
          check("mem_wdata", mem_wdata, e.d);
          check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e.s});
        end
      end
      if (mem_we) begin
        w = mem_rd(mem_addr);
        for (int i = 0; i < 4; i++)
          if (mem_wstrb[i]) w[i*8 +: 8] = mem_wdata[i*8 +: 8];
        mem[mem_addr] = w;
      end else begin
        mem_rdata = mem_rd(mem_addr);
      end
    end
  end

  function automatic vec_t mk(input string n, input logic rd, input logic wr, input logic [2:0] ls,
                              input logic [31:0] a, input logic [31:0] wd, input int stall,
                              input logic [31:0] rdata, input logic [31:0] wdat, input logic [3:0] strb);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.ls = ls; v.a = a; v.wd = wd;
    v.stall = stall; v.rdata = rdata; v.wdat = wdat; v.strb = strb;
    return v;
  endfunction

  task automatic push_refill(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      t.we = 1'b0; t.a = {a[31:4], 4'b0} + 32'(4*i); t.d = '0; t.s = '0;
      exp_q.push_back(t);
    end
  endtask

  task automatic run(input vec_t v);
    int cyc = 0;
    if (v.wr) begin
      txn_t t;
      t.we = 1'b1; t.a = {v.a[31:2], 2'b00}; t.d = v.wdat; t.s = v.strb;
      exp_q.push_back(t);
    end else if (v.stall > 0) begin
      push_refill(v.a, 4);
    end
    @(posedge clk); #1;
    memread = v.rd; memwrite = v.wr; load_store = v.ls; addr = v.a; wdata = v.wd;
    forever begin
      @(negedge clk);
      if (!miss) break;
      cyc++;
      if (cyc > 50) break;
    end
    check({v.name, "_stall"}, 32'(cyc), 32'(v.stall));
    if (!v.wr)
      check({v.name, "_rdata"}, readdata, v.rdata);
  endtask

  vec_t vt[$];

  initial begin
    rst = 1'b1; memread = 0; memwrite = 0; load_store = 3'b010; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    mem[32'h100] = 32'h11111111; mem[32'h104] = 32'h22222222;
    mem[32'h108] = 32'h33333333; mem[32'h10C] = 32'h44444444;
    mem[32'h200] = 32'h80FF7F01;
    mem[32'h500] = 32'h55550000; mem[32'h504] = 32'h55550004;

    vt.push_back(mk("lw_miss_100",   1, 0, 3'b010, 32'h100,  0,            5, 32'h11111111, 0, 0));
    vt.push_back(mk("lw_hit_108",    1, 0, 3'b010, 32'h108,  0,            0, 32'h33333333, 0, 0));
    vt.push_back(mk("lw_miss_200",   1, 0, 3'b010, 32'h200,  0,            5, 32'h80FF7F01, 0, 0));
    vt.push_back(mk("lb_203",        1, 0, 3'b000, 32'h203,  0,            0, 32'hFFFFFF80, 0, 0));
    vt.push_back(mk("lbu_203",       1, 0, 3'b011, 32'h203,  0,            0, 32'h00000080, 0, 0));
    vt.push_back(mk("lh_202",        1, 0, 3'b001, 32'h202,  0,            0, 32'hFFFF80FF, 0, 0));
    vt.push_back(mk("lhu_200",       1, 0, 3'b100, 32'h200,  0,            0, 32'h00007F01, 0, 0));
    vt.push_back(mk("sb_202",        0, 1, 3'b101, 32'h202,  32'h123456AB, 2, 0, 32'hABABABAB, 4'b0100));
    vt.push_back(mk("lw_after_sb",   1, 0, 3'b010, 32'h200,  0,            0, 32'h80AB7F01, 0, 0));
    vt.push_back(mk("sw_3000",       0, 1, 3'b111, 32'h3000, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 4'b1111));
    vt.push_back(mk("lw_miss_3000",  1, 0, 3'b010, 32'h3000, 0,            5, 32'hDEADBEEF, 0, 0));
    vt.push_back(mk("lw_evict_500",  1, 0, 3'b010, 32'h500,  0,            5, 32'h55550000, 0, 0));
    vt.push_back(mk("lw_refill_100", 1, 0, 3'b010, 32'h100,  0,            5, 32'h11111111, 0, 0));
    vt.push_back(mk("sh_106",        0, 1, 3'b110, 32'h106,  32'h0000BEEF, 2, 0, 32'hBEEFBEEF, 4'b1100));
    vt.push_back(mk("lw_after_sh",   1, 0, 3'b010, 32'h104,  0,            0, 32'hBEEF2222, 0, 0));
    vt.push_back(mk("rd_wr_both",    1, 1, 3'b111, 32'h10C,  32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 4'b1111));
    vt.push_back(mk("lw_after_both", 1, 0, 3'b010, 32'h10C,  0,            0, 32'hCAFEF00D, 0, 0));
    vt.push_back(mk("idle",          0, 0, 3'b010, 32'h100,  0,            0, 32'h0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miss", {31'b0, miss}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vt[i]) run(vt[i]);

    // Reset in the middle of a refill: two words accepted, then the transaction is dropped
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_refill(32'h100, 2);
    @(posedge clk); #1;
    memread = 1; memwrite = 0; load_store = 3'b010; addr = 32'h100;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; memread = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem_req", {31'b0, mem_req}, 32'h0);
    check("midrst_miss", {31'b0, miss}, 32'h0);
    check("midrst_txns_left", 32'(exp_q.size()), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run(mk("lw_after_rst", 1, 0, 3'b010, 32'h100, 0, 5, 32'h11111111, 0, 0));
    run(mk("lw_hit_after_rst", 1, 0, 3'b010, 32'h10C, 0, 0, 32'hCAFEF00D, 0, 0));

    @(posedge clk); #1 memread = 0;
    repeat (2) @(posedge clk);
    check("txns_left", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/d_cache.md
Name: d_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. It is the responder on the CPU datapath's MEM-stage memory interface.
- It takes the MEM-stage address, store data and load/store type from the datapath. It returns `readdata` and the `miss` stall, which freezes every pipeline register while high.
- On the far side it acts as initiator to a word-wide backing memory with a req/ack handshake. Line refills use multi-word bursts.

Parameters:
- DATA_WIDTH, 32, CPU and memory word width.
- INDEX_BITS, 6, log2 of the number of lines (64).
- OFFSET_BITS, 2, log2 of words per line (4). Tag width is 32-INDEX_BITS-OFFSET_BITS-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memread  in  1  MEM-stage load request.
- memwrite  in  1  MEM-stage store request.
- load_store  in  3  access type: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101 sb, 110 sh, 111 sw.
- addr  in  32  byte address (alu_result_M).
- wdata  in  32  store data, right-aligned.
- readdata  out  32  load result, extended per load_store.
- miss  out  1  stall; high while the current access cannot complete this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write data, byte-lane replicated.
- mem_wstrb  out  4  byte enables for writes.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion of the current word.

Behaviour:
- Address split: offset = addr[OFFSET_BITS+1:2], index = next INDEX_BITS bits, tag = the rest.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. No misalignment fault.
- Storage: data array, tag array and valid bits. Data and tag arrays are not reset; valid bits clear on rst.
- FSM states:
  - IDLE.
  - REFILL: 2-bit word counter `cnt`.
  - WRITE.
  - WDONE.
- Reset: state=IDLE, cnt=0, all valid=0, miss=0, mem_req=0, mem_we=0, readdata=0 when not reading.
  - Reset mid-REFILL or mid-WRITE abandons the transaction: mem_req drops the cycle after the rst edge. The partially refilled line stays invalid.
- IDLE:
  - memread and hit (valid & tag match):
    - miss=0.
    - readdata is combinational from the array this cycle.
    - lb/lh sign-extend, lbu/lhu zero-extend.
    - Byte select is addr[1:0]; half select is addr[1].
  - memread and not hit: miss=1, cnt=0, go to REFILL.
  - memwrite: miss=1, go to WRITE (every store costs a memory write).
  - memread and memwrite both high: the store takes priority.
  - Neither high: miss=0, readdata=0.
- REFILL:
  - miss=1, mem_req=1, mem_we=0.
  - mem_addr = {tag, index, cnt, 2'b00}.
  - Each cycle with mem_ack: data[index][cnt] <= mem_rdata, cnt increments.
  - On the ack with cnt=max: tag written, valid set, go to IDLE.
  - The re-lookup then hits and miss drops.
  - mem_ack may arrive in the first REFILL cycle. mem_addr is held stable until ack.
- WRITE:
  - miss=1, mem_req=1, mem_we=1.
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_wdata: sb replicates wdata[7:0] ×4, sh replicates wdata[15:0] ×2, sw passes wdata.
  - mem_wstrb: sb = 1<<addr[1:0], sh = 0011 or 1100 by addr[1], sw = 1111.
  - On mem_ack: if hit, merge the bytes under wstrb into the cached word; if miss, no allocate. Go to WDONE.
- WDONE: miss=0 for exactly one cycle so the pipeline advances, then go to IDLE.
- Input stability: the CPU holds memread, memwrite, load_store, addr and wdata stable while miss=1, because the pipeline is frozen. The cache does not latch them.
- Latency with mem_ack every cycle:
  - Load hit: 0 stall cycles.
  - Load miss: miss high for 2+2^OFFSET_BITS-1 cycles (5 at defaults).
  - Store: miss high for 2 cycles.
- mem_req is a Moore output of the state; it never asserts in IDLE or WDONE.

Test Plan:
- After rst: lw 0x100 with memory words 0x100..0x10C = 0x11111111, 0x22222222, 0x33333333, 0x44444444, ack every cycle.
  - Expect mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - miss high for 5 cycles, then miss=0 and readdata=0x11111111.
  - A following lw 0x108 hits: miss=0, readdata=0x33333333.
- Word 0x80FF7F01 cached at 0x200:
  - lb 0x203 gives 0xFFFFFF80; lbu 0x203 gives 0x00000080.
  - lh 0x202 gives 0xFFFF80FF; lhu 0x200 gives 0x00007F01.
  - miss stays 0 throughout.
- sb 0x202, wdata 0x123456AB, on a cached line holding 0x80FF7F01 at 0x200:
  - Expect mem_we=1, mem_addr=0x200, mem_wstrb=0100, mem_wdata=0xABABABAB.
  - miss high for 2 cycles.
  - Then lw 0x200 hits with 0x80AB7F01.
- sw 0x3000 (uncached), wdata 0xDEADBEEF:
  - One write with mem_wstrb=1111, no refill issued.
  - A following lw 0x3000 misses and refills.
- Conflict: lw 0x100 (refill), lw 0x500 (same index, refill, evicts), then lw 0x100.
  - Expect a third refill, with mem_addr starting at 0x100.
- Reset mid-refill: rst asserted after 2 acks during the lw 0x100 refill.
  - Expect mem_req=0 and miss=0 the next cycle.
  - A subsequent lw 0x100 misses and refills all 4 words.
